// File: rtl/nw_score_read_sequencer.sv
// Neighbour-score read sequencer for the NW fill engine: fetches M[i][j], M[i][j+1] and M[i+1][j] for one cell.
// Optional feature: define RD_BYPASS_EN to forward write-port snoop data into reads still in flight.
module nw_score_read_sequencer #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int ADDR_W  = $clog2((N + 1) * (N + 1)),
  parameter int SCORE_W = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BitAddr:0]          i,
  input  logic [BitAddr:0]          j,
  output logic                      busy,
  output logic                      err,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic signed [SCORE_W-1:0] rd_data,
  output logic signed [SCORE_W-1:0] score_diag,
  output logic signed [SCORE_W-1:0] score_left,
  output logic signed [SCORE_W-1:0] score_up,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      snp_we,
  input  logic [ADDR_W-1:0]         snp_addr,
  input  logic signed [SCORE_W-1:0] snp_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_e;

  localparam logic [BitAddr:0]  NMax   = (BitAddr + 1)'(N);
  localparam logic [ADDR_W-1:0] RowLen = ADDR_W'(N + 1);
  localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);
  localparam logic [1:0]        TagDiag = 2'd1;
  localparam logic [1:0]        TagLeft = 2'd2;
  localparam logic [1:0]        TagUp   = 2'd3;

  state_e state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d, j_q, j_d;
  logic rd_en_q, rd_en_d, err_q, err_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic signed [SCORE_W-1:0] diag_q, diag_d, left_q, left_d, up_q, up_d;
  logic [1:0] tag_q [RD_LAT];
  logic [1:0] tag_d [RD_LAT];
  logic [1:0] exit_tag;
  logic signed [SCORE_W-1:0] cap_data;
  logic [ADDR_W-1:0] start_base, start_j;

  assign start_j    = ADDR_W'(j);
  assign start_base = RowLen * ADDR_W'(i);
  assign exit_tag   = tag_q[RD_LAT-1];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    j_d       = j_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (i < NMax && j < NMax) begin
            base_d    = start_base;
            j_d       = start_j;
            wr_addr_d = start_base + start_j + RowLen + One;
            rd_en_d   = 1'b1;
            rd_addr_d = start_base + start_j;
            k_d       = 2'd0;
            state_d   = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // rd_en/rd_addr are registered, so each ISSUE cycle prepares the next read on the bus
      ISSUE: begin
        case (k_q)
          2'd0: begin
            rd_en_d   = 1'b1;
            rd_addr_d = base_q + j_q + One;
            k_d       = 2'd1;
          end
          2'd1: begin
            rd_en_d   = 1'b1;
            rd_addr_d = base_q + RowLen + j_q;
            k_d       = 2'd2;
          end
          default: state_d = DRAIN;
        endcase
      end
      DRAIN: begin
        if (exit_tag == TagUp) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag 0 marks an empty slot; a read's tag equals k+1 of the ISSUE step that launched it
  always_comb begin
    tag_d[0] = rd_en_q ? (k_q + 2'd1) : 2'd0;
    for (int s = 1; s < RD_LAT; s++) tag_d[s] = tag_q[s-1];
    diag_d = diag_q;
    left_d = left_q;
    up_d   = up_q;
    case (exit_tag)
      TagDiag: diag_d = cap_data;
      TagLeft: left_d = cap_data;
      TagUp:   up_d   = cap_data;
      default: ;
    endcase
  end

`ifdef RD_BYPASS_EN
  logic [ADDR_W-1:0] baddr_q [RD_LAT];
  logic [ADDR_W-1:0] baddr_d [RD_LAT];
  logic byp_v_q [RD_LAT];
  logic byp_v_d [RD_LAT];
  logic signed [SCORE_W-1:0] byp_data_q [RD_LAT];
  logic signed [SCORE_W-1:0] byp_data_d [RD_LAT];

  // A snoop hit overwrites any earlier one, so the most recent write to that address wins
  always_comb begin
    baddr_d[0]    = rd_addr_q;
    byp_v_d[0]    = rd_en_q && snp_we && (snp_addr == rd_addr_q);
    byp_data_d[0] = snp_data;
    for (int s = 1; s < RD_LAT; s++) begin
      baddr_d[s] = baddr_q[s-1];
      if (snp_we && tag_q[s-1] != 2'd0 && snp_addr == baddr_q[s-1]) begin
        byp_v_d[s]    = 1'b1;
        byp_data_d[s] = snp_data;
      end else begin
        byp_v_d[s]    = byp_v_q[s-1];
        byp_data_d[s] = byp_data_q[s-1];
      end
    end
    cap_data = rd_data;
    if (snp_we && snp_addr == baddr_q[RD_LAT-1]) cap_data = snp_data;
    else if (byp_v_q[RD_LAT-1]) cap_data = byp_data_q[RD_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        baddr_q[s]    <= '0;
        byp_v_q[s]    <= 1'b0;
        byp_data_q[s] <= '0;
      end
    end else begin
      baddr_q    <= baddr_d;
      byp_v_q    <= byp_v_d;
      byp_data_q <= byp_data_d;
    end
  end
`else
  logic unused_snp;
  assign unused_snp = ^{snp_we, snp_addr, snp_data};
  assign cap_data   = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= 2'd0;
      base_q    <= '0;
      j_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      diag_q    <= '0;
      left_q    <= '0;
      up_q      <= '0;
      for (int s = 0; s < RD_LAT; s++) tag_q[s] <= 2'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      base_q    <= base_d;
      j_q       <= j_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      diag_q    <= diag_d;
      left_q    <= left_d;
      up_q      <= up_d;
      tag_q     <= tag_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == HOLD);
  assign err        = err_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign wr_addr    = wr_addr_q;
  assign score_diag = diag_q;
  assign score_left = left_q;
  assign score_up   = up_q;

endmodule

// File: tb/tb_nw_score_read_sequencer.sv
// Scoreboard bench for nw_score_read_sequencer: N=4 with RD_LAT=1 (main instance) and RD_LAT=3 (second instance).
module tb_nw_score_read_sequencer;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int SW = 16;
  localparam int BA = 3;
  localparam logic signed [SW-1:0] Poison = 16'sh7BAD;
`ifdef RD_BYPASS_EN
  localparam bit BypassOn = 1'b1;
`else
  localparam bit BypassOn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic start1, busy1, err1, rd_en1, out_valid1, out_ready1, snp_we1;
  logic [BA:0] i1, j1;
  logic [AW-1:0] rd_addr1, wr_addr1, snp_addr1;
  logic signed [SW-1:0] rd_data1, diag1, left1, up1, snp_data1;

  logic start3, busy3, err3, rd_en3, out_valid3, out_ready3, snp_we3;
  logic [BA:0] i3, j3;
  logic [AW-1:0] rd_addr3, wr_addr3, snp_addr3;
  logic signed [SW-1:0] rd_data3, diag3, left3, up3, snp_data3;

  nw_score_read_sequencer #(.N(N), .SCORE_W(SW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .i(i1), .j(j1), .busy(busy1), .err(err1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .score_diag(diag1),
    .score_left(left1), .score_up(up1), .wr_addr(wr_addr1), .out_valid(out_valid1),
    .out_ready(out_ready1), .snp_we(snp_we1), .snp_addr(snp_addr1), .snp_data(snp_data1));

  nw_score_read_sequencer #(.N(N), .SCORE_W(SW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .i(i3), .j(j3), .busy(busy3), .err(err3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3), .score_diag(diag3),
    .score_left(left3), .score_up(up3), .wr_addr(wr_addr3), .out_valid(out_valid3),
    .out_ready(out_ready3), .snp_we(snp_we3), .snp_addr(snp_addr3), .snp_data(snp_data3));

  // Score RAM models: latency 1 and latency 3, poison value outside the valid window
  logic signed [SW-1:0] mem [25];
  logic [AW-1:0] r1_addr, r3_addr [3];
  logic r1_v, r3_v [3];
  always @(posedge clk) begin
    r1_addr <= rd_addr1;
    r1_v    <= rd_en1;
    r3_addr[0] <= rd_addr3;
    r3_v[0]    <= rd_en3;
    r3_addr[1] <= r3_addr[0];
    r3_v[1]    <= r3_v[0];
    r3_addr[2] <= r3_addr[1];
    r3_v[2]    <= r3_v[1];
  end
  assign rd_data1 = r1_v ? mem[r1_addr] : Poison;
  assign rd_data3 = r3_v[2] ? mem[r3_addr[2]] : Poison;

  typedef struct {
    logic [AW-1:0] wr;
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] l;
    logic signed [SW-1:0] u;
  } res_t;

  res_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  res_t mon_r;
  int n_checks = 0;
  int n_fail = 0;
  int cycle_cnt = 0;
  int t0 = 0;
  int rd3_cnt = 0;
  int res3_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ii, input int jj, input bit use_left, input logic signed [SW-1:0] left_val);
    res_t r;
    int base;
    base = 5 * ii;
    addr_q.push_back(AW'(base + jj));
    addr_q.push_back(AW'(base + jj + 1));
    addr_q.push_back(AW'(base + 5 + jj));
    r.wr = AW'(base + jj + 6);
    r.d  = mem[base + jj];
    r.l  = use_left ? left_val : mem[base + jj + 1];
    r.u  = mem[base + 5 + jj];
    exp_q.push_back(r);
    start1 = 1'b1;
    i1 = 4'(ii);
    j1 = 4'(jj);
    tick();
    start1 = 1'b0;
    t0 = cycle_cnt - 1;
  endtask

  task automatic waitResult(input int exp_lat, input int hold);
    int n;
    n = 0;
    while (!out_valid1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("latency", 32'(cycle_cnt - t0), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", 32'(out_valid1), 32'd1);
      if (exp_q.size() > 0) begin
        checkOutput("hold_left", 32'(left1), 32'(exp_q[0].l));
        checkOutput("hold_wr_addr", 32'(wr_addr1), 32'(exp_q[0].wr));
      end
      tick();
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    checkOutput("valid_drop", 32'(out_valid1), 32'd0);
    checkOutput("busy_drop", 32'(busy1), 32'd0);
  endtask

  task automatic checkReset();
    checkOutput("rst_rd_en", 32'(rd_en1), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr1), 32'd0);
    checkOutput("rst_err", 32'(err1), 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    checkOutput("rst_valid", 32'(out_valid1), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr1), 32'd0);
    checkOutput("rst_diag", 32'(diag1), 32'd0);
    checkOutput("rst_left", 32'(left1), 32'd0);
    checkOutput("rst_up", 32'(up1), 32'd0);
  endtask

  // Monitor: read addresses and handshaken results are popped from the scoreboard
  always @(negedge clk) begin
    if (rd_en1) begin
      if (addr_q.size() == 0) checkOutput("rd_en_spurious", 32'(rd_en1), 32'd0);
      else checkOutput("rd_addr", 32'(rd_addr1), 32'(addr_q.pop_front()));
    end
    if (out_valid1 && out_ready1) begin
      if (exp_q.size() == 0) checkOutput("result_spurious", 32'(out_valid1), 32'd0);
      else begin
        mon_r = exp_q.pop_front();
        checkOutput("score_diag", 32'(diag1), 32'(mon_r.d));
        checkOutput("score_left", 32'(left1), 32'(mon_r.l));
        checkOutput("score_up", 32'(up1), 32'(mon_r.u));
        checkOutput("wr_addr", 32'(wr_addr1), 32'(mon_r.wr));
      end
    end
    if (rd_en3) rd3_cnt <= rd3_cnt + 1;
    if (out_valid3 && out_ready3) res3_cnt <= res3_cnt + 1;
  end

  initial begin
    int n;
    for (int a = 0; a < 25; a++) mem[a] = 16'(a * 7 - 50);
    mem[7] = 16'sd3;   mem[8] = -16'sd1;   mem[12] = 16'sd5;
    mem[18] = 16'sd100; mem[19] = -16'sd200; mem[23] = 16'sd300;
    mem[0] = 16'sd11;  mem[1] = -16'sd22;  mem[5] = 16'sd33;
    rst = 1'b1;
    start1 = 0; i1 = 0; j1 = 0; out_ready1 = 0; snp_we1 = 0; snp_addr1 = 0; snp_data1 = 0;
    start3 = 0; i3 = 0; j3 = 0; out_ready3 = 0; snp_we3 = 0; snp_addr3 = 0; snp_data3 = 0;
    repeat (3) tick();
    rst = 1'b0;
    checkReset();
    tick();

    $display("[TB] cell (1,2) with backpressure");
    applyStimulus(1, 2, 1'b0, 16'sd0);
    waitResult(5, 4);

    $display("[TB] out-of-range starts");
    start1 = 1'b1; i1 = 4'd4; j1 = 4'd0;
    tick();
    start1 = 1'b0;
    checkOutput("err_pulse_i", 32'(err1), 32'd1);
    checkOutput("err_busy_i", 32'(busy1), 32'd0);
    tick();
    checkOutput("err_clear_i", 32'(err1), 32'd0);
    start1 = 1'b1; i1 = 4'd0; j1 = 4'd4;
    tick();
    start1 = 1'b0;
    checkOutput("err_pulse_j", 32'(err1), 32'd1);
    repeat (4) tick();
    checkOutput("err_no_read", 32'(rd_en1), 32'd0);
    checkOutput("err_idle_busy", 32'(busy1), 32'd0);

    $display("[TB] corner cell (3,3) then back-to-back (2,0), out_ready held high");
    out_ready1 = 1'b1;
    tick();
    applyStimulus(3, 3, 1'b0, 16'sd0);
    waitResult(5, 0);
    out_ready1 = 1'b1;
    applyStimulus(2, 0, 1'b0, 16'sd0);
    waitResult(5, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(2, 1, 1'b0, 16'sd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checkReset();
    applyStimulus(0, 0, 1'b0, 16'sd0);
    waitResult(5, 0);

    $display("[TB] snoop write to the left address while it is in flight");
    applyStimulus(1, 2, BypassOn, 16'sd9);
    tick();
    snp_we1 = 1'b1; snp_addr1 = 5'd8; snp_data1 = 16'sd9;
    tick();
    snp_we1 = 1'b0;
    waitResult(5, 0);

    $display("[TB] RD_LAT=3 with a start while busy");
    start3 = 1'b1; i3 = 4'd1; j3 = 4'd2;
    tick();
    start3 = 1'b0;
    t0 = cycle_cnt - 1;
    tick();
    start3 = 1'b1; i3 = 4'd0; j3 = 4'd0;
    tick();
    start3 = 1'b0;
    checkOutput("lat3_busy_err", 32'(err3), 32'd0);
    n = 0;
    while (!out_valid3 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("lat3_latency", 32'(cycle_cnt - t0), 32'd7);
    checkOutput("lat3_diag", 32'(diag3), 32'(mem[7]));
    checkOutput("lat3_left", 32'(left3), 32'(mem[8]));
    checkOutput("lat3_up", 32'(up3), 32'(mem[12]));
    checkOutput("lat3_wr_addr", 32'(wr_addr3), 32'd13);
    out_ready3 = 1'b1;
    tick();
    out_ready3 = 1'b0;
    checkOutput("lat3_valid_drop", 32'(out_valid3), 32'd0);
    repeat (12) tick();
    checkOutput("lat3_read_count", 32'(rd3_cnt), 32'd3);
    checkOutput("lat3_result_count", 32'(res3_cnt), 32'd1);

    checkOutput("addr_scoreboard_empty", 32'(addr_q.size()), 32'd0);
    checkOutput("result_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
